// File: rtl/dmem_access_unit_if.sv
// Memory-side bus of the MEM-stage data-memory access unit: a req/ack
// handshake towards a variable-latency data memory.
interface dmem_access_unit_if #(
   parameter int DATA_W = 32
);
   logic              mem_req_o;
   logic              mem_we_o;
   logic [DATA_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;

   // The access unit issues requests and the data memory answers them.
   modport master (
      output mem_req_o,
      output mem_we_o,
      output mem_addr_o,
      output mem_wdata_o,
      input  mem_ack_i,
      input  mem_rdata_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_we_o,
      input  mem_addr_o,
      input  mem_wdata_o,
      output mem_ack_i,
      output mem_rdata_i
   );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit. Turns the load/store held in EX/MEM
// into one req/ack transaction, stalls the whole pipeline while it is in
// flight, registers the loaded word for MEM/WB and aborts accesses that
// are never acknowledged (sticky err_o).
module dmem_access_unit #(
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              err_o,
   dmem_access_unit_if.master mem
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Byte-offset bits are dropped: only word accesses exist.
   localparam logic [DATA_W-1:0] WORD_MASK = ~DATA_W'(3);
   localparam logic [7:0]        MAX_CNT   = 8'(MAX_WAIT);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] wait_cnt_q;
   logic       start;
   logic       ack_hit;
   logic       timeout;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, stall and datapath enables. Ack is looked at only in WAIT,
   // where mem_req_o is always high, and beats a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      start   = 1'b0;
      ack_hit = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemRead_i || MemWrite_i) begin
               stall_o = 1'b1;
               start   = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            stall_o = 1'b1;
            if (mem.mem_ack_i) begin
               ack_hit = 1'b1;
               state_d = DONE;
            end else if (wait_cnt_q == MAX_CNT) begin
               timeout = 1'b1;
               state_d = DONE;
            end
         end
         // EX/MEM still shows the finished instruction here; ignore it.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, wait counter, load data and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem.mem_req_o   <= 1'b0;
         mem.mem_we_o    <= 1'b0;
         mem.mem_addr_o  <= '0;
         mem.mem_wdata_o <= '0;
         wait_cnt_q      <= '0;
         rdata_o         <= '0;
         err_o           <= 1'b0;
      end else begin
         if (start) begin
            mem.mem_req_o   <= 1'b1;
            mem.mem_we_o    <= MemWrite_i;
            mem.mem_addr_o  <= addr_i & WORD_MASK;
            mem.mem_wdata_o <= wdata_i;
            wait_cnt_q      <= '0;
         end else if (ack_hit) begin
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) begin
               rdata_o <= mem.mem_rdata_i;
            end
         end else if (timeout) begin
            mem.mem_req_o <= 1'b0;
            err_o         <= 1'b1;
            if (!mem.mem_we_o) begin
               rdata_o <= '0;
            end
         end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed load/store sequence against a small
// memory responder, with expected requests and load data queued when each
// access is issued and checked when the DUT produces them.
module tb_dmem_access_unit;

   localparam int MAX_A = 4;
   localparam int MAX_B = 2;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        rd_a = 1'b0, wr_a = 1'b0;
   logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
   logic        stall_a, err_a;

   logic        rd_b = 1'b0, wr_b = 1'b0;
   logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;
   logic        stall_b, err_b;

   dmem_access_unit_if #(.DATA_W(32)) bus_a ();
   dmem_access_unit_if #(.DATA_W(32)) bus_b ();

   dmem_access_unit #(.DATA_W(32), .MAX_WAIT(MAX_A)) dut_a (
      .clk_i      (clk),
      .rst_i      (rst),
      .MemRead_i  (rd_a),
      .MemWrite_i (wr_a),
      .addr_i     (addr_a),
      .wdata_i    (wdata_a),
      .rdata_o    (rdata_a),
      .stall_o    (stall_a),
      .err_o      (err_a),
      .mem        (bus_a)
   );

   dmem_access_unit #(.DATA_W(32), .MAX_WAIT(MAX_B)) dut_b (
      .clk_i      (clk),
      .rst_i      (rst),
      .MemRead_i  (rd_b),
      .MemWrite_i (wr_b),
      .addr_i     (addr_b),
      .wdata_i    (wdata_b),
      .rdata_o    (rdata_b),
      .stall_o    (stall_b),
      .err_o      (err_b),
      .mem        (bus_b)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   req_t        exp_req_q[$];
   logic [31:0] exp_rd_q[$];
   logic [31:0] model_rdata = '0;
   logic        model_err   = 1'b0;

   // memory responder state for dut_a
   int          ack_delay    = -1;
   logic [31:0] ack_data     = '0;
   int          req_age      = 0;
   int          req_count    = 0;
   int          req_hi_cycles = 0;
   logic        model_ack    = 1'b0;
   logic        force_ack    = 1'b0;

   assign bus_a.mem_ack_i = model_ack | force_ack;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Memory model: ack k cycles after req rises; pops the expected request.
   always @(posedge clk) begin
      req_t e;
      #1;
      if (bus_a.mem_req_o) begin
         if (req_age == 0) begin
            req_count++;
            if (exp_req_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
            end else begin
               e = exp_req_q.pop_front();
               chk("req_addr", bus_a.mem_addr_o, e.addr);
               chk("req_we", 32'(bus_a.mem_we_o), 32'(e.we));
               chk("req_wdata", bus_a.mem_wdata_o, e.wdata);
            end
         end
         req_hi_cycles++;
         model_ack = (req_age == ack_delay);
         req_age++;
      end else begin
         req_age   = 0;
         model_ack = 1'b0;
      end
      bus_a.mem_rdata_i = ack_data;
   end

   // One access on dut_a; k<0 means never acknowledged.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int k, input logic [31:0] rv,
                         input string tag);
      req_t e;
      bit   to;
      int   exp_st, st, req0, hi0;
      to       = (k < 0) || (k > MAX_A);
      e.we     = wr;
      e.addr   = {a[31:2], 2'b00};
      e.wdata  = wd;
      exp_req_q.push_back(e);
      if (!wr) model_rdata = to ? 32'd0 : rv;
      if (to) model_err = 1'b1;
      exp_rd_q.push_back(model_rdata);
      exp_st   = to ? MAX_A + 2 : k + 2;
      ack_delay = k;
      ack_data  = rv;
      req0 = req_count;
      hi0  = req_hi_cycles;
      rd_a = rd; wr_a = wr; addr_a = a; wdata_a = wd;
      st = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!stall_a) break;
         st++;
      end
      // DONE cycle
      chk({tag, "_stall_cycles"}, 32'(st), 32'(exp_st));
      chk({tag, "_rdata"}, rdata_a, exp_rd_q.pop_front());
      chk({tag, "_err"}, 32'(err_a), 32'(model_err));
      chk({tag, "_req_count"}, 32'(req_count - req0), 32'd1);
      chk({tag, "_req_hi"}, 32'(req_hi_cycles - hi0), 32'(exp_st - 1));
      chk({tag, "_req_low_done"}, 32'(bus_a.mem_req_o), 32'd0);
      @(posedge clk); #1;
      rd_a = 1'b0; wr_a = 1'b0;
   endtask

   initial begin
      bus_b.mem_ack_i   = 1'b0;
      bus_b.mem_rdata_i = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall_a), 32'd0);
      chk("rst_req", 32'(bus_a.mem_req_o), 32'd0);
      chk("rst_we", 32'(bus_a.mem_we_o), 32'd0);
      chk("rst_addr", bus_a.mem_addr_o, 32'd0);
      chk("rst_wdata", bus_a.mem_wdata_o, 32'd0);
      chk("rst_rdata", rdata_a, 32'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      chk("rst_b_outs", {bus_b.mem_addr_o[29:0], bus_b.mem_req_o, bus_b.mem_we_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, "rd_k0");
      access(1'b0, 1'b1, 32'h0000_0203, 32'h1234_5678, 3, 32'hFFFF_0000, "wr_k3");

      // non-memory instructions: no stall, no request
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nomem_stall", 32'(stall_a), 32'd0);
         chk("nomem_req", 32'(bus_a.mem_req_o), 32'd0);
      end
      @(posedge clk); #1;

      access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h0000_0011, "b2b_1");
      access(1'b1, 1'b0, 32'h0000_0344, 32'h0, 1, 32'h0000_0022, "b2b_2");
      access(1'b1, 1'b1, 32'h0000_0410, 32'hA5A5_5A5A, 2, 32'h0BAD_0BAD, "rdwr_store_wins");
      access(1'b1, 1'b0, 32'h0000_0500, 32'h0, -1, 32'h7777_7777, "timeout");
      access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 0, 32'h0000_55AA, "after_to");
      access(1'b0, 1'b1, 32'h0000_0700, 32'h0000_0042, 1, 32'h0, "wr_after_to");

      // reset in the middle of WAIT, then a late ack
      begin
         req_t e;
         int   req0;
         e.we = 1'b0; e.addr = 32'h0000_0800; e.wdata = 32'h0;
         exp_req_q.push_back(e);
         ack_delay = -1;
         rd_a = 1'b1; addr_a = 32'h0000_0800; wdata_a = 32'h0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("midwait_req_high", 32'(bus_a.mem_req_o), 32'd1);
         req0 = req_count;
         rst = 1'b1; rd_a = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0; force_ack = 1'b1;
         model_rdata = '0; model_err = 1'b0;
         @(negedge clk);
         chk("rstw_req", 32'(bus_a.mem_req_o), 32'd0);
         chk("rstw_stall", 32'(stall_a), 32'd0);
         chk("rstw_addr", bus_a.mem_addr_o, 32'd0);
         chk("rstw_rdata", rdata_a, 32'd0);
         chk("rstw_err", 32'(err_a), 32'd0);
         @(posedge clk); #1;
         force_ack = 1'b0;
         @(negedge clk);
         chk("late_ack_req", 32'(bus_a.mem_req_o), 32'd0);
         chk("late_ack_stall", 32'(stall_a), 32'd0);
         chk("late_ack_rdata", rdata_a, 32'd0);
         chk("late_ack_count", 32'(req_count - req0), 32'd0);
         @(posedge clk); #1;
      end

      access(1'b1, 1'b0, 32'h0000_0904, 32'h0, 0, 32'h1357_9BDF, "post_rst");

      // dut_b (MAX_WAIT=2): ack arrives in the cycle the counter reaches 2
      rd_b = 1'b1; addr_b = 32'h0000_0A00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus_b.mem_ack_i = 1'b1; bus_b.mem_rdata_i = 32'hCAFE_F00D;
      @(negedge clk);
      chk("sim_req_high", 32'(bus_b.mem_req_o), 32'd1);
      chk("sim_stall_high", 32'(stall_b), 32'd1);
      @(posedge clk); #1;
      bus_b.mem_ack_i = 1'b0;
      @(negedge clk);
      chk("sim_stall_done", 32'(stall_b), 32'd0);
      chk("sim_rdata", rdata_b, 32'hCAFE_F00D);
      chk("sim_err", 32'(err_b), 32'd0);
      chk("sim_addr", bus_b.mem_addr_o, 32'h0000_0A00);
      @(posedge clk); #1;
      rd_b = 1'b0;
      repeat (2) @(posedge clk);

      chk("exp_req_q_empty", 32'(exp_req_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

MEM-stage data-memory access unit for the 5-stage pipelined CPU. Takes the load/store request held in the EX/MEM pipeline register, runs a req/ack handshake with a variable-latency data memory, and raises `stall_o` to freeze the whole pipeline until the access completes. The loaded word is registered and presented to the MEM/WB register. A watchdog aborts accesses that never get acknowledged.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.
- `MAX_WAIT`, 255, number of WAIT cycles without ack before timeout (1..255; counter is 8 bits).

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `MemRead_i`  in  1  load request from EX/MEM.
- `MemWrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  32  byte address (ALU result).
- `wdata_i`  in  32  store data (rs2 data).
- `rdata_o`  out  32  loaded word, to MEM/WB.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle.
- `err_o`  out  1  sticky timeout flag.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 = write, 0 = read; valid while `mem_req_o`=1.
- `mem_addr_o`  out  32  word address `{addr[31:2],2'b00}`, latched.
- `mem_wdata_o`  out  32  latched store data.
- `mem_ack_i`  in  1  memory completion, one-cycle pulse.
- `mem_rdata_i`  in  32  read data, valid with `mem_ack_i`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If `MemRead_i|MemWrite_i`: latch address, data and `we` (`we = MemWrite_i`; store wins if both are set). Set `mem_req_o`=1 from the next cycle, clear the wait counter, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable.
  - On `mem_ack_i`=1: drop `mem_req_o`. For a read, capture `mem_rdata_i` into `rdata_o`. Go to DONE.
  - Else the counter increments. When the counter reaches `MAX_WAIT`: drop `mem_req_o`, set `err_o`=1, load `rdata_o`=0 for reads, go to DONE.
  - Ack and timeout in the same cycle: ack wins, `err_o` unchanged.
- DONE:
  - `stall_o`=0, so the pipeline advances and MEM/WB captures `rdata_o`.
  - `MemRead_i`/`MemWrite_i` are ignored, because they still show the completed instruction.
  - Next state IDLE.
- `stall_o` = (IDLE & (MemRead_i|MemWrite_i)) | WAIT. It is combinational from the state and the inputs.
- `rdata_o` holds its value until the next read completion. Stores and non-memory instructions do not change it.
- `mem_ack_i` is ignored whenever `mem_req_o`=0.
- `addr_i[1:0]` is discarded. Only word accesses are supported.
- `err_o` clears only on reset.

## Timing
- Reset values: state IDLE, `stall_o`=0 (given no request), `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_o`=0, `err_o`=0, counter 0.
- Reset mid-access (WAIT): next cycle is IDLE with `mem_req_o`=0. An ack arriving after reset is ignored.
- Access with ack arriving k cycles after `mem_req_o` rises (k ≥ 0, same-cycle ack = 0):
  - stall duration: k+2 cycles (IDLE cycle + k+1 WAIT cycles);
  - DONE is the cycle after the ack;
  - `rdata_o` is valid from DONE onward.
- Minimum access: 2 stall cycles, then DONE.
- Timeout: `mem_req_o` is high for `MAX_WAIT`+1 cycles. `err_o` rises in the DONE cycle. Stall duration is `MAX_WAIT`+2 cycles.
- Back-to-back memory instructions: DONE → IDLE → new request. The second access starts in the cycle after DONE, so there is no lost or duplicated access.
- Non-memory instructions cause no stall and no request.

## Test plan
- Read, ack at k=0:
  - stimulus: `MemRead_i`=1, `addr_i`=0x0000_0104, memory returns 0xDEAD_BEEF;
  - required: `stall_o` high exactly 2 cycles, `mem_addr_o`=0x104, `mem_we_o`=0, `rdata_o`=0xDEAD_BEEF in DONE, one request only.
- Write, ack at k=3:
  - stimulus: `MemWrite_i`=1, `addr_i`=0x0000_0203, `wdata_i`=0x1234_5678;
  - required: `mem_addr_o`=0x200, `mem_wdata_o`=0x1234_5678, `mem_we_o`=1; stall 5 cycles; `rdata_o` unchanged.
- Back-to-back:
  - stimulus: a load (returns 0x11) followed by a load to a different address (returns 0x22), both acked at k=1;
  - required: exactly two requests; `rdata_o` 0x11 then 0x22; no duplicate request during DONE.
- Timeout:
  - stimulus: `MAX_WAIT`=4, read, no ack;
  - required: `mem_req_o` high 5 cycles; `err_o`=1 in DONE; `rdata_o`=0; `err_o` stays 1 through later accesses until `rst_i`.
- Reset mid-WAIT:
  - stimulus: assert `rst_i` in WAIT, then pulse `mem_ack_i`;
  - required: next cycle `mem_req_o`=0, `stall_o`=0, all outputs 0; the late ack has no effect.
- Simultaneous ack and timeout:
  - stimulus: `MAX_WAIT`=2, ack in the cycle the counter reaches 2;
  - required: data captured, `err_o`=0.
